// File: rtl/fp_issue_pkg.sv
// Shared RV32F decode constants for the FP issue buffer and its scoreboard.
// Opcode values, instruction field positions and source-usage helpers.
package fp_issue_pkg;

  localparam int REG_W     = 5;
  localparam int NUM_FREGS = 32;

  localparam logic [6:0] OP_FP  = 7'b1010011;
  localparam logic [6:0] FMADD  = 7'b1000011;
  localparam logic [6:0] FMSUB  = 7'b1000111;
  localparam logic [6:0] FNMSUB = 7'b1001011;
  localparam logic [6:0] FNMADD = 7'b1001111;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int RS3_LSB = 27;
  localparam int RS3_MSB = 31;

  function automatic logic uses_rs3(input logic [6:0] opcode);
    return (opcode == FMADD) || (opcode == FMSUB) ||
           (opcode == FNMSUB) || (opcode == FNMADD);
  endfunction

  // Only these opcodes participate in hazard checks and scoreboard updates.
  function automatic logic is_fp_class(input logic [6:0] opcode);
    return (opcode == OP_FP) || uses_rs3(opcode);
  endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// FP register scoreboard: pending bits set on issue, cleared on writeback; set beats clear.
// Hazard is combinational from rd/rs1/rs2/rs3; FP_ISSUE_WB_BYPASS_EN lets a same-cycle writeback unblock it.
// Pending updates are registered, so a new bit blocks dependents from the next cycle.
import fp_issue_pkg::*;

module fp_scoreboard (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_en,
  input  logic [REG_W-1:0]     set_rd,
  input  logic                 clr_en,
  input  logic [REG_W-1:0]     clr_rd,
  input  logic                 chk_en,
  input  logic                 chk_rs3,
  input  logic [REG_W-1:0]     rd,
  input  logic [REG_W-1:0]     rs1,
  input  logic [REG_W-1:0]     rs2,
  input  logic [REG_W-1:0]     rs3,
  output logic                 hazard,
  output logic [NUM_FREGS-1:0] pending
);

  logic [NUM_FREGS-1:0] set_mask;
  logic [NUM_FREGS-1:0] clr_mask;
  logic [NUM_FREGS-1:0] view;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd] = 1'b1;
  end

`ifdef FP_ISSUE_WB_BYPASS_EN
  assign view = pending & ~clr_mask;
`else
  assign view = pending;
`endif

  assign hazard = chk_en & (view[rs1] | view[rs2] | (chk_rs3 & view[rs3]) | view[rd]);

  // Set is applied after clear: the newly issued op owns the register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pending <= '0;
    else       pending <= (pending & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/fp_issue_buffer.sv
// RV32F issue FIFO releasing its head to the FPU only when the scoreboard shows no RAW/WAW hazard.
// Latency: a push is issuable no earlier than the next cycle; optional FP_ISSUE_WB_BYPASS_EN writeback bypass.
// Backpressure: instr_ready_o = !full (no pass-through when full); head waits for issue_ready_i.
import fp_issue_pkg::*;

module fp_issue_buffer #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_valid_i,
  input  logic [DATAWIDTH-1:0]     instr_i,
  output logic                     instr_ready_o,
  output logic                     issue_valid_o,
  output logic [DATAWIDTH-1:0]     issue_instr_o,
  input  logic                     issue_ready_i,
  input  logic                     wb_valid_i,
  input  logic [4:0]               wb_rd_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              pending_o,
  output logic                     stall_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 hazard;
  logic [DATAWIDTH-1:0] head;
  logic [6:0]           head_opc;
  logic                 head_fp;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr];

  assign head_opc = head[OPC_MSB:OPC_LSB];
  assign head_fp  = is_fp_class(head_opc);

  assign instr_ready_o = !full;
  assign issue_valid_o = !empty && !hazard;
  assign stall_o       = !empty && hazard;
  assign issue_instr_o = empty ? '0 : head;
  assign count_o       = count;

  assign push = instr_valid_i && instr_ready_o && !flush_i;
  assign pop  = issue_valid_o && issue_ready_i && !flush_i;

  fp_scoreboard u_scoreboard (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .set_en  (pop && head_fp),
    .set_rd  (head[RD_MSB:RD_LSB]),
    .clr_en  (wb_valid_i),
    .clr_rd  (wb_rd_i),
    .chk_en  (head_fp),
    .chk_rs3 (uses_rs3(head_opc)),
    .rd      (head[RD_MSB:RD_LSB]),
    .rs1     (head[RS1_MSB:RS1_LSB]),
    .rs2     (head[RS2_MSB:RS2_LSB]),
    .rs3     (head[RS3_MSB:RS3_LSB]),
    .hazard  (hazard),
    .pending (pending_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= instr_i;
    end
  end

  // Flush drops everything buffered; in-flight ops keep their pending bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_issue_buffer.sv
// Directed, table-driven bench for fp_issue_buffer plus hand sequences for flush and async reset.
module tb_fp_issue_buffer;

`ifdef FP_ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] F3  = 32'h002081D3;  // fadd.s f3,f1,f2
  localparam logic [31:0] MUL = 32'h10118253;  // fmul.s f4,f3,f1
  localparam logic [31:0] A5  = 32'h007302D3;  // fadd.s f5,f6,f7
  localparam logic [31:0] F7  = 32'h002083D3;  // fadd.s f7,f1,f2
  localparam logic [31:0] F11 = 32'h002085D3;  // fadd.s f11,f1,f2
  localparam logic [31:0] FMA = 32'h58A48443;  // fmadd.s f8,f9,f10,f11
  localparam logic [31:0] IB  = 32'h00100093;  // addi x1,x0,1
  localparam logic [31:0] IC  = 32'h00200113;
  localparam logic [31:0] ID  = 32'h00300193;
  localparam logic [31:0] IE  = 32'h00400213;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic        instr_ready_o;
  logic        issue_valid_o;
  logic [31:0] issue_instr_o;
  logic        issue_ready_i;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_i;
  logic        flush_i;
  logic [2:0]  count_o;
  logic [31:0] pending_o;
  logic        stall_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_issue_buffer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .instr_ready_o (instr_ready_o),
    .issue_valid_o (issue_valid_o),
    .issue_instr_o (issue_instr_o),
    .issue_ready_i (issue_ready_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_i       (wb_rd_i),
    .flush_i       (flush_i),
    .count_o       (count_o),
    .pending_o     (pending_o),
    .stall_o       (stall_o)
  );

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic        rdy;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [2:0]  e_cnt;
    logic        e_ivld;
    logic [31:0] e_instr;
    logic        e_stall;
    logic        e_ready;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl[40];
  int   nvec = 0;

  task automatic add(input logic iv, input logic [31:0] ins, input logic rdy,
                     input logic wbv, input logic [4:0] wbrd,
                     input logic [2:0] c, input logic v, input logic [31:0] ei,
                     input logic s, input logic r, input logic [31:0] p);
    tbl[nvec].iv = iv;     tbl[nvec].instr = ins;  tbl[nvec].rdy = rdy;
    tbl[nvec].wbv = wbv;   tbl[nvec].wbrd = wbrd;
    tbl[nvec].e_cnt = c;   tbl[nvec].e_ivld = v;   tbl[nvec].e_instr = ei;
    tbl[nvec].e_stall = s; tbl[nvec].e_ready = r;  tbl[nvec].e_pend = p;
    nvec++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive inputs just after a falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic iv, input logic [31:0] ins, input logic rdy,
                       input logic wbv, input logic [4:0] wbrd, input logic fl);
    @(negedge clk);
    instr_valid_i = iv;
    instr_i       = ins;
    issue_ready_i = rdy;
    wb_valid_i    = wbv;
    wb_rd_i       = wbrd;
    flush_i       = fl;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " count"},   32'(count_o), 32'd0);
    chk({tag, " ivld"},    32'(issue_valid_o), 32'd0);
    chk({tag, " instr"},   issue_instr_o, 32'd0);
    chk({tag, " ready"},   32'(instr_ready_o), 32'd1);
    chk({tag, " stall"},   32'(stall_o), 32'd0);
    chk({tag, " pending"}, pending_o, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0; issue_ready_i = 1'b0;
    wb_valid_i = 1'b0; wb_rd_i = '0; flush_i = 1'b0;

    //   iv  instr rdy wbv rd | cnt ivld instr stall rdy pend
    add(0, 0,   0, 0, 0,   0, 0,    0,   0,    1, 32'h0);
    add(1, F3,  1, 0, 0,   0, 0,    0,   0,    1, 32'h0);
    add(0, 0,   1, 0, 0,   1, 1,    F3,  0,    1, 32'h0);
    add(0, 0,   0, 0, 0,   0, 0,    0,   0,    1, 32'h8);
    add(1, MUL, 1, 0, 0,   0, 0,    0,   0,    1, 32'h8);
    add(0, 0,   1, 0, 0,   1, 0,    MUL, 1,    1, 32'h8);
    add(0, 0,   1, 1, 3,   1, BYP,  MUL, !BYP, 1, 32'h8);
    if (BYP) add(0, 0, 1, 0, 0, 0, 0, 0,   0, 1, 32'h10);
    else     add(0, 0, 1, 0, 0, 1, 1, MUL, 0, 1, 32'h0);
    add(0, 0,   0, 0, 0,   0, 0,    0,   0,    1, 32'h10);
    // Fill to full with ready low, fifth push refused, then drain in order.
    add(1, A5,  0, 0, 0,   0, 0,    0,   0,    1, 32'h10);
    add(1, IB,  0, 0, 0,   1, 1,    A5,  0,    1, 32'h10);
    add(1, IC,  0, 0, 0,   2, 1,    A5,  0,    1, 32'h10);
    add(1, ID,  0, 0, 0,   3, 1,    A5,  0,    1, 32'h10);
    add(1, IE,  0, 0, 0,   4, 1,    A5,  0,    0, 32'h10);
    add(1, IE,  1, 0, 0,   4, 1,    A5,  0,    0, 32'h10);
    add(0, 0,   1, 0, 0,   3, 1,    IB,  0,    1, 32'h30);
    add(0, 0,   1, 0, 0,   2, 1,    IC,  0,    1, 32'h30);
    add(0, 0,   1, 0, 0,   1, 1,    ID,  0,    1, 32'h30);
    add(0, 0,   0, 0, 0,   0, 0,    0,   0,    1, 32'h30);
    add(0, 0,   0, 1, 5,   0, 0,    0,   0,    1, 32'h30);
    add(0, 0,   0, 1, 4,   0, 0,    0,   0,    1, 32'h10);
    // Issue to f5 with a same-cycle writeback of f5: the set must survive.
    add(1, A5,  0, 0, 0,   0, 0,    0,   0,    1, 32'h0);
    add(0, 0,   1, 1, 5,   1, 1,    A5,  0,    1, 32'h0);
    add(0, 0,   0, 0, 0,   0, 0,    0,   0,    1, 32'h20);
    add(0, 0,   0, 1, 5,   0, 0,    0,   0,    1, 32'h20);
    add(0, 0,   0, 0, 0,   0, 0,    0,   0,    1, 32'h0);
    // Fused op blocked only by its rs3 source.
    add(1, F11, 1, 0, 0,   0, 0,    0,   0,    1, 32'h0);
    add(1, FMA, 1, 0, 0,   1, 1,    F11, 0,    1, 32'h0);
    add(0, 0,   1, 0, 0,   1, 0,    FMA, 1,    1, 32'h800);
    add(0, 0,   1, 1, 11,  1, BYP,  FMA, !BYP, 1, 32'h800);
    if (BYP) add(0, 0, 1, 0, 0, 0, 0, 0,   0, 1, 32'h100);
    else     add(0, 0, 1, 0, 0, 1, 1, FMA, 0, 1, 32'h0);
    add(0, 0,   0, 0, 0,   0, 0,    0,   0,    1, 32'h100);

    #3;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_i = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      drive(tbl[i].iv, tbl[i].instr, tbl[i].rdy, tbl[i].wbv, tbl[i].wbrd, 1'b0);
      chk($sformatf("row%0d count", i),   32'(count_o),       32'(tbl[i].e_cnt));
      chk($sformatf("row%0d ivld", i),    32'(issue_valid_o), 32'(tbl[i].e_ivld));
      chk($sformatf("row%0d instr", i),   issue_instr_o,      tbl[i].e_instr);
      chk($sformatf("row%0d stall", i),   32'(stall_o),       32'(tbl[i].e_stall));
      chk($sformatf("row%0d ready", i),   32'(instr_ready_o), 32'(tbl[i].e_ready));
      chk($sformatf("row%0d pending", i), pending_o,          tbl[i].e_pend);
    end

    // Flush with f3 pending, three entries buffered and an FP head that would otherwise issue.
    drive(1, F3, 1, 0, 0, 0);
    drive(0, 0,  1, 0, 0, 0);
    drive(1, F7, 0, 0, 0, 0);
    drive(1, IB, 0, 0, 0, 0);
    drive(1, IC, 0, 0, 0, 0);
    drive(0, 0,  0, 0, 0, 0);
    chk("preflush count", 32'(count_o), 32'd3);
    chk("preflush instr", issue_instr_o, F7);
    chk("preflush pending", pending_o, 32'h108);
    drive(1, ID, 1, 0, 0, 1);
    drive(0, 0,  0, 0, 0, 0);
    chk("flush count", 32'(count_o), 32'd0);
    chk("flush ivld", 32'(issue_valid_o), 32'd0);
    chk("flush instr", issue_instr_o, 32'd0);
    chk("flush pending", pending_o, 32'h108);
    drive(1, ID, 0, 0, 0, 0);
    drive(1, IE, 0, 0, 0, 0);
    drive(0, 0,  0, 0, 0, 0);
    chk("postflush count", 32'(count_o), 32'd2);
    chk("postflush instr", issue_instr_o, ID);

    // Asynchronous reset between clock edges.
    #1;
    rst_i = 1'b1;
    #1;
    chk_reset_vals("async reset");
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk_reset_vals("after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_issue_buffer.md
# fp_issue_buffer

Instruction issue stage directly upstream of the FP wrapper: buffers incoming RV32F instruction words in a small FIFO and releases the head only when the FP unit accepts it (`issue_ready_i`, tied to the FPU `in_ready_o`). Release also requires a register scoreboard to show no RAW or WAW hazard on the floating-point register file. Writeback notifications from the downstream stage clear scoreboard entries.

## Interface
- `DATAWIDTH`, 32: instruction word width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `instr_valid_i` in 1: upstream instruction valid.
- `instr_i` in DATAWIDTH: instruction word.
- `instr_ready_o` out 1: buffer can accept; `!full`.
- `issue_valid_o` out 1: head instruction may issue.
- `issue_instr_o` out DATAWIDTH: head instruction; 0 when empty.
- `issue_ready_i` in 1: FP unit accepts.
- `wb_valid_i` in 1: an FP result is written back this cycle.
- `wb_rd_i` in 5: writeback destination register.
- `flush_i` in 1: discard all buffered instructions.
- `count_o` out $clog2(DEPTH)+1: occupancy.
- `pending_o` out 32: scoreboard, bit n = f-reg n awaits writeback.
- `stall_o` out 1: head present but blocked by a hazard.

## Operation
- Push when `instr_valid_i && instr_ready_o && !flush_i`. Pop (issue) when `issue_valid_o && issue_ready_i`.
- Field decode of the head: rd[11:7], rs1[19:15], rs2[24:20], rs3[31:27], opcode[6:0].
- Sources checked: OP-FP (1010011) checks rs1 and rs2. FMADD/FMSUB/FNMSUB/FNMADD (1000011/1000111/1001011/1001111) check rs1, rs2 and rs3. Any other opcode checks nothing and sets no scoreboard bit; it is passed through so the decoder can flag it illegal.
- Hazard = any checked source pending, or rd pending (WAW). Only FP-class opcodes are checked.
- `issue_valid_o = !empty && !hazard`. `stall_o = !empty && hazard`.
- On issue of an FP-class instruction, set `pending[rd]`. On `wb_valid_i`, clear `pending[wb_rd_i]`.
- Set and clear of the same bit in one cycle: set wins, because the new instruction owns the register.
- Flush empties the FIFO (pointers and count reset). The scoreboard is untouched, since in-flight ops still write back. A pop in the flush cycle is suppressed.
- Simultaneous push and pop when non-empty: count unchanged. Push when full is refused even if a pop occurs that cycle; there is no same-cycle pass-through.
- Pointers wrap modulo DEPTH. Count saturates structurally and never exceeds DEPTH.

## Timing
- Reset values: count 0, pointers 0, pending 0, `issue_valid_o` 0, `issue_instr_o` 0, `instr_ready_o` 1, `stall_o` 0.
- Latency: an instruction pushed in cycle N is at the head and issuable no earlier than cycle N+1.
- Scoreboard update is registered: a bit set by issue in cycle N blocks dependents from cycle N+1.
- `issue_valid_o` does not depend on `issue_ready_i`. Once asserted, it remains asserted until the issue fires or a flush occurs, because pending bits cannot newly set without an issue.
- Reset asserted mid-operation immediately clears all state, including pending bits.

## Configuration
- `FP_ISSUE_WB_BYPASS_EN` defined: the hazard check uses `pending & ~(wb_valid_i ? 1<<wb_rd_i : 0)`. A dependent blocked only by the register being written back issues in the same cycle as `wb_valid_i`.
- Undefined: the hazard check uses registered `pending` only. The dependent issues at the earliest one cycle after `wb_valid_i`.

## Structure
- Shared package `fp_issue_pkg`:
  - opcode localparams (OP_FP, FMADD, FMSUB, FNMSUB, FNMADD);
  - field bit-position constants;
  - function `uses_rs3(opcode)`.
- One sub-module `fp_scoreboard`:
  - holds the 32-bit pending register and its set/clear/priority logic;
  - produces the hazard bit from rd/rs1/rs2/rs3 plus use flags, with the bypass macro applied inside it.
- The FIFO storage, pointers and count stay in `fp_issue_buffer`.

## Test plan
- Reset, then push `fadd.s f3,f1,f2` (0x002081D3) with `issue_ready_i`=1 → issues the next cycle; `pending_o`=0x00000008.
- Push fadd to f3, then `fmul.s f4,f3,f1` → fmul held with `stall_o`=1. Then `wb_valid_i`=1 with `wb_rd_i`=3 → fmul issues the same cycle when the bypass macro is defined, one cycle later when it is not.
- Push 4 instructions with `issue_ready_i`=0 → `count_o`=4, `instr_ready_o`=0. A fifth push is refused. Raise ready → all 4 drain in order over 4 cycles, pointers wrap correctly.
- Issue fadd to f5 and, in the same cycle, write back `wb_rd_i`=5 → `pending_o[5]` remains 1.
- FIFO at 3 entries, f3 pending, assert `flush_i` → `count_o`=0, `issue_valid_o`=0, `pending_o[3]` still 1.
- Assert `rst_i` mid-stream → all outputs return to their reset values asynchronously.
